// File: rtl/ibex_pkg.sv
// Shared CHERI definitions: violation bit positions in the memory exception vector and
// the permission index used for instruction fetch checks.
package ibex_pkg;

  typedef enum int unsigned {
    TAG_VIOLATION       = 0,
    SEAL_VIOLATION      = 1,
    LOAD_VIOLATION      = 2,
    STORE_VIOLATION     = 3,
    EXECUTE_VIOLATION   = 4,
    LENGTH_VIOLATION    = 5,
    ALIGNMENT_VIOLATION = 6
  } cheri_violation_e;

  localparam int unsigned CheriExcWidth      = 7;
  localparam int unsigned PermitExecuteIndex = 4;

  // Access size in bytes for a data_type encoding.
  function automatic logic [3:0] access_size(logic [1:0] data_type);
    logic [3:0] size;
    case (data_type)
      2'b00:   size = 4'd4;
      2'b01:   size = 4'd2;
      2'b10:   size = 4'd1;
      default: size = 4'd8;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/ibex_cheri_exc_fifo.sv
// Small FIFO holding per-request exception entries until the matching response arrives.
// Pointers wrap modulo Depth; occupancy lives in its own counter.
module ibex_cheri_exc_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] mem_q [Depth];

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    wptr_d  = push_i ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop_i ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (!push_i && pop_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while occupancy covers them.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ibex_cheri_memcheck_queue.sv
// Checks each granted access against the authority capability and queues the verdict until
// its response returns. Optional capability alignment check: IBEX_CHERI_CAP_ALIGN_EN.
module ibex_cheri_memcheck_queue
  import ibex_pkg::*;
#(
  parameter bit          DataMem        = 1'b1,
  parameter bit          StableOut      = 1'b1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     auth_tag_i,
  input  logic                     auth_sealed_i,
  input  logic [30:0]              auth_perms_i,
  input  logic [31:0]              auth_base_i,
  input  logic [32:0]              auth_top_i,
  input  logic                     data_req_i,
  input  logic                     data_gnt_i,
  input  logic                     data_rvalid_i,
  input  logic [31:0]              data_addr_i,
  input  logic                     data_we_i,
  input  logic [1:0]               data_type_i,
  input  logic [3:0]               data_be_i,
  input  logic                     data_cap_i,
  output logic                     data_req_o,
  output logic                     data_gnt_o,
  output logic                     data_we_o,
  output logic [CheriExcWidth-1:0] cheri_mem_exc_o,
  output logic                     instr_upper_exc_o,
  output logic                     queue_err_o
);

  localparam int unsigned EntryW = CheriExcWidth + 1;

  logic [3:0]               size;
  logic [1:0]               low_bits;
  logic [31:0]              act_addr, upper_addr;
  logic [32:0]              act_end, upper_end;
  logic [CheriExcWidth-1:0] exc_d;
  logic                     upper_d;
  logic [EntryW-1:0]        head, stable_q, resp;
  logic                     push, pop, full, empty, full_gate;
  logic                     err_q;
  logic                     unused_sig;

  always_comb begin
    size     = 4'd2;
    low_bits = 2'b00;
    if (DataMem) begin
      size = access_size(data_type_i);
      if (data_be_i[0])      low_bits = 2'b00;
      else if (data_be_i[1]) low_bits = 2'b01;
      else if (data_be_i[2]) low_bits = 2'b10;
      else                   low_bits = 2'b11;
    end
  end

  assign act_addr   = {data_addr_i[31:2], low_bits};
  assign upper_addr = {data_addr_i[31:2], 2'b10};
  assign act_end    = {1'b0, act_addr} + {29'd0, size};
  assign upper_end  = {1'b0, upper_addr} + 33'd2;

  always_comb begin
    exc_d                    = '0;
    exc_d[TAG_VIOLATION]     = ~auth_tag_i;
    exc_d[SEAL_VIOLATION]    = auth_sealed_i;
    exc_d[LOAD_VIOLATION]    = ~data_we_i & ~auth_perms_i[2];
    exc_d[STORE_VIOLATION]   = data_we_i & ~auth_perms_i[3];
    exc_d[EXECUTE_VIOLATION] = !DataMem & ~auth_perms_i[PermitExecuteIndex];
    exc_d[LENGTH_VIOLATION]  = (act_addr < auth_base_i) | (act_end > auth_top_i);
`ifdef IBEX_CHERI_CAP_ALIGN_EN
    exc_d[ALIGNMENT_VIOLATION] = DataMem & data_cap_i & (act_addr[2:0] != 3'b000);
`endif
  end

  assign upper_d   = !DataMem & (upper_end > auth_top_i);
  assign data_we_o = data_we_i & ~|exc_d;

  // A response popping in this cycle frees a slot, so a full queue may still accept a request.
  assign pop        = data_rvalid_i & ~empty;
  assign full_gate  = full & ~pop;
  assign data_req_o = data_req_i & ~full_gate;
  assign data_gnt_o = data_gnt_i & ~full_gate;
  assign push       = data_req_o & data_gnt_i;

  ibex_cheri_exc_fifo #(
    .Width (EntryW),
    .Depth (MaxOutstanding)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({upper_d, exc_d}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  if (StableOut) begin : g_stable
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stable_q <= '0;
      end else if (pop) begin
        stable_q <= head;
      end
    end
  end else begin : g_unstable
    assign stable_q = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (data_rvalid_i && empty) begin
      err_q <= 1'b1;
    end
  end

  always_comb begin
    resp = stable_q;
    if (data_rvalid_i) begin
      resp = empty ? '0 : head;
    end
  end

  assign cheri_mem_exc_o   = resp[CheriExcWidth-1:0];
  assign instr_upper_exc_o = resp[EntryW-1];
  assign queue_err_o       = err_q;

  assign unused_sig = ^{auth_perms_i, data_cap_i, data_addr_i[1:0]};

endmodule

// File: tb/tb_ibex_cheri_memcheck_queue.sv
// Bench for ibex_cheri_memcheck_queue: a data-port instance and an instruction-port instance
// driven by directed steps then random traffic, checked against a queue-based model.
module tb_ibex_cheri_memcheck_queue;
  import ibex_pkg::*;

  localparam int unsigned MaxA = 2;
  localparam int unsigned MaxB = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        auth_tag, sealed, we, cap;
  logic [30:0] perms;
  logic [31:0] base, addr;
  logic [32:0] top;
  logic [1:0]  dtype;
  logic [3:0]  be;
  logic        a_req, a_gnt, a_rv, b_req, b_gnt, b_rv;
  logic        a_req_o, a_gnt_o, a_we_o, a_up, a_err;
  logic        b_req_o, b_gnt_o, b_we_o, b_up, b_err;
  logic [6:0]  a_exc, b_exc;

  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [7:0]  sa;
  logic        erra, errb;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ibex_cheri_memcheck_queue #(
    .DataMem (1'b1), .StableOut (1'b1), .MaxOutstanding (MaxA)
  ) dut_a (
    .clk_i (clk), .rst_i (rst), .auth_tag_i (auth_tag), .auth_sealed_i (sealed),
    .auth_perms_i (perms), .auth_base_i (base), .auth_top_i (top),
    .data_req_i (a_req), .data_gnt_i (a_gnt), .data_rvalid_i (a_rv), .data_addr_i (addr),
    .data_we_i (we), .data_type_i (dtype), .data_be_i (be), .data_cap_i (cap),
    .data_req_o (a_req_o), .data_gnt_o (a_gnt_o), .data_we_o (a_we_o),
    .cheri_mem_exc_o (a_exc), .instr_upper_exc_o (a_up), .queue_err_o (a_err)
  );

  ibex_cheri_memcheck_queue #(
    .DataMem (1'b0), .StableOut (1'b0), .MaxOutstanding (MaxB)
  ) dut_b (
    .clk_i (clk), .rst_i (rst), .auth_tag_i (auth_tag), .auth_sealed_i (sealed),
    .auth_perms_i (perms), .auth_base_i (base), .auth_top_i (top),
    .data_req_i (b_req), .data_gnt_i (b_gnt), .data_rvalid_i (b_rv), .data_addr_i (addr),
    .data_we_i (we), .data_type_i (dtype), .data_be_i (be), .data_cap_i (cap),
    .data_req_o (b_req_o), .data_gnt_o (b_gnt_o), .data_we_o (b_we_o),
    .cheri_mem_exc_o (b_exc), .instr_upper_exc_o (b_up), .queue_err_o (b_err)
  );

  task automatic chk_b(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference verdict {upper, exc} from the current access and authority.
  function automatic logic [7:0] model_entry(bit dm);
    logic [7:0]      e;
    longint unsigned a, up, sz, bl, tl;
    int              lo;
    bl = base;
    tl = top;
    if (dm) begin
      case (dtype)
        2'd0:    sz = 4;
        2'd1:    sz = 2;
        2'd2:    sz = 1;
        default: sz = 8;
      endcase
      lo = 3;
      for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
      a = longint'({addr[31:2], 2'b00}) + longint'(lo);
    end else begin
      sz = 2;
      a  = longint'({addr[31:2], 2'b00});
    end
    up = longint'({addr[31:2], 2'b00}) + 2;
    e = 8'h00;
    e[TAG_VIOLATION]     = !auth_tag;
    e[SEAL_VIOLATION]    = sealed;
    e[LOAD_VIOLATION]    = !we && !perms[2];
    e[STORE_VIOLATION]   = we && !perms[3];
    e[EXECUTE_VIOLATION] = !dm && !perms[PermitExecuteIndex];
    e[LENGTH_VIOLATION]  = (a < bl) || (a + sz > tl);
`ifdef IBEX_CHERI_CAP_ALIGN_EN
    e[ALIGNMENT_VIOLATION] = dm && cap && (a[2:0] != 3'b000);
`endif
    e[7] = !dm && (up + 2 > tl);
    return e;
  endfunction

  // Compare combinational outputs with the model, away from the clock edge.
  task automatic settle();
    logic [7:0] ea, eb, ha, hb;
    bit         fga, fgb;
    @(negedge clk);
    ea  = model_entry(1'b1);
    eb  = model_entry(1'b0);
    fga = (qa.size() == MaxA) && !(a_rv && qa.size() > 0);
    fgb = (qb.size() == MaxB) && !(b_rv && qb.size() > 0);
    ha  = a_rv ? ((qa.size() > 0) ? qa[0] : 8'h00) : sa;
    hb  = (b_rv && qb.size() > 0) ? qb[0] : 8'h00;
    chk_b("a_req", a_req_o, a_req && !fga);
    chk_b("a_gnt", a_gnt_o, a_gnt && !fga);
    chk_b("a_we", a_we_o, we && (ea[6:0] == 7'd0));
    chk_v("a_resp", {a_up, a_exc}, ha);
    chk_b("b_req", b_req_o, b_req && !fgb);
    chk_b("b_gnt", b_gnt_o, b_gnt && !fgb);
    chk_b("b_we", b_we_o, we && (eb[6:0] == 7'd0));
    chk_v("b_resp", {b_up, b_exc}, hb);
  endtask

  // Advance the model across a rising edge, then check sticky and occupancy state.
  task automatic tick();
    bit         popa, popb, pusha, pushb;
    logic [7:0] ea, eb;
    @(posedge clk);
    ea    = model_entry(1'b1);
    eb    = model_entry(1'b0);
    popa  = a_rv && qa.size() > 0;
    popb  = b_rv && qb.size() > 0;
    pusha = a_req && a_gnt && !((qa.size() == MaxA) && !popa);
    pushb = b_req && b_gnt && !((qb.size() == MaxB) && !popb);
    if (rst) begin
      qa.delete();
      qb.delete();
      sa   = 8'h00;
      erra = 1'b0;
      errb = 1'b0;
    end else begin
      if (a_rv && qa.size() == 0) erra = 1'b1;
      if (b_rv && qb.size() == 0) errb = 1'b1;
      if (popa) sa = qa.pop_front();
      if (popb) void'(qb.pop_front());
      if (pusha) qa.push_back(ea);
      if (pushb) qb.push_back(eb);
    end
    #1;
    chk_b("a_err", a_err, erra);
    chk_b("b_err", b_err, errb);
    chk_i("a_occ", int'(dut_a.u_fifo.count_q), qa.size());
  endtask

  task automatic set_a(logic r, logic g, logic v);
    a_req = r; a_gnt = g; a_rv = v;
  endtask

  task automatic set_b(logic r, logic g, logic v);
    b_req = r; b_gnt = g; b_rv = v;
  endtask

  initial begin
    rst = 1'b1; auth_tag = 1'b1; sealed = 1'b0; perms = '1; base = 32'h0;
    top = 33'h1_0000_0000; addr = 32'h0; we = 1'b0; dtype = 2'b00; be = 4'hF; cap = 1'b0;
    set_a(0, 0, 0);
    set_b(0, 0, 0);
    sa = 8'h00; erra = 1'b0; errb = 1'b0;
    tick();
    settle();
    chk_v("reset_resp", {a_up, a_exc}, 8'h00);
    tick();
    rst = 1'b0;

    // In-bounds word load, then a word load one past the top.
    base = 32'h1000; top = 33'h1010; addr = 32'h100C;
    set_a(1, 1, 0); settle(); tick();
    addr = 32'h1010; settle(); tick();
    set_a(0, 0, 1); settle(); chk_v("r032_ok", {a_up, a_exc}, 8'h00); tick();
    settle(); chk_b("r032_len", a_exc[LENGTH_VIOLATION], 1'b1); tick();

    // Three back-to-back requests against a two-entry queue.
    addr = 32'h100C; set_a(1, 1, 0); settle(); tick();
    addr = 32'h1010; settle(); tick();
    addr = 32'h1004; settle();
    chk_b("r033_gnt", a_gnt_o, 1'b0);
    chk_b("r033_req", a_req_o, 1'b0);
    tick();
    set_a(0, 0, 1); settle(); chk_v("r033_first", {a_up, a_exc}, 8'h00); tick();

    // Refill to full, then push and pop in the same cycle.
    addr = 32'h1008; set_a(1, 1, 0); settle(); tick();
    addr = 32'h1000; we = 1'b1; perms[3] = 1'b0;
    set_a(1, 1, 1); settle();
    chk_b("r034_gnt", a_gnt_o, 1'b1);
    chk_v("r034_head", {a_up, a_exc}, 8'h20);
    tick();
    chk_i("r034_occ", int'(dut_a.u_fifo.count_q), 2);
    we = 1'b0; perms = '1;
    set_a(0, 0, 1); settle(); chk_v("r034_second", {a_up, a_exc}, 8'h00); tick();
    settle(); chk_v("r034_third", {a_up, a_exc}, 8'h08); tick();
    set_a(0, 0, 0); settle(); chk_v("a_stable", {a_up, a_exc}, 8'h08); tick();

    // Store without store permission.
    we = 1'b1; perms[3] = 1'b0; addr = 32'h1000;
    set_a(1, 1, 0); settle(); chk_b("r035_we", a_we_o, 1'b0); tick();
    we = 1'b0; perms = '1;
    set_a(0, 0, 1); settle(); chk_b("r035_store", a_exc[STORE_VIOLATION], 1'b1); tick();
    set_a(0, 0, 0);

    // Instruction fetch whose upper halfword crosses the top.
    base = 32'h2000; top = 33'h2002; addr = 32'h2000;
    set_b(1, 1, 0); settle(); tick();
    set_b(0, 0, 1); settle();
    chk_b("r036_len", b_exc[LENGTH_VIOLATION], 1'b0);
    chk_b("r036_upper", b_up, 1'b1);
    tick();
    set_b(0, 0, 0); settle(); chk_v("b_idle", {b_up, b_exc}, 8'h00); tick();

    // Response with nothing outstanding, then reset.
    set_a(0, 0, 1); settle(); chk_v("r037_resp", {a_up, a_exc}, 8'h00); tick();
    chk_b("r037_err", a_err, 1'b1);
    set_a(0, 0, 0); settle(); tick(); settle(); tick();
    chk_b("r037_hold", a_err, 1'b1);
    rst = 1'b1; settle(); tick();
    rst = 1'b0;
    chk_b("r037_clr", a_err, 1'b0);
    chk_i("r037_occ", int'(dut_a.u_fifo.count_q), 0);

    for (int n = 0; n < 500; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      auth_tag = ($urandom_range(0, 9) != 0);
      sealed   = ($urandom_range(0, 9) == 0);
      perms    = 31'($urandom);
      base     = 32'h1000 + 32'($urandom_range(0, 64));
      top      = {1'b0, base} + 33'($urandom_range(0, 32));
      addr     = 32'h0FF0 + 32'($urandom_range(0, 128));
      we       = 1'($urandom);
      dtype    = 2'($urandom);
      be       = 4'($urandom);
      cap      = 1'($urandom);
      set_a(1'($urandom), 1'($urandom), 1'($urandom));
      set_b(1'($urandom), 1'($urandom), 1'($urandom));
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
